seq_param_calculator: RTL and testbench
=======================================

# seq_param_calculator

Clocked, parametrised successor to the combinational switch calculator. It takes two WIDTH-bit operands and a 3-bit opcode from board switches. A debounced press of the active-low KEY0 pushes button runs one operation through a small capture/execute FSM. The registered result, status flags and two active-low hex digits stay held until the next press. It sits directly under the board top level, between the switch/key pins and the 7-segment displays.

## Interface
- WIDTH, 4: operand and result width in bits; legal range 2..8.
- DEBOUNCE_CYCLES, 4: consecutive stable cycles required before a button level change is accepted; minimum 1.
- clk  in  1  system clock, single domain.
- rst_n  in  1  synchronous, active-low reset.
- a  in  WIDTH  operand A (switches).
- b  in  WIDTH  operand B (switches).
- op  in  3  operation select (switches).
- btn_n  in  1  raw KEY0; asynchronous to clk; 0 = pressed.
- out  out  WIDTH  registered result.
- flags  out  4  {N,Z,C,V}.
- busy  out  1  high while the FSM is not in IDLE.
- done  out  1  one-cycle pulse when out/flags update.
- seg_lo  out  7  hex digit of result[3:0]; active-low gfedcba, bit0 = segment a.
- seg_hi  out  7  hex digit of result[7:4]; bits at or above WIDTH read as 0.

## Operation
- btn_n input path:
  - Passes through a 2-flop synchroniser, then a debouncer.
  - The debounced level flips only after the synchronised value differs from it for DEBOUNCE_CYCLES consecutive cycles.
  - Any shorter glitch resets the counter.
- press_pulse: a one-cycle registered pulse on each debounced 1->0 transition. Releases generate nothing.
- FSM states, one cycle each except IDLE:
  - IDLE: wait; on press_pulse go to CAPTURE.
  - CAPTURE: register a, b and op.
  - EXEC: compute and register out and flags.
  - DONE: done=1, then back to IDLE.
- Presses arriving while busy=1 are discarded, not queued.
- Opcodes; all results are modulo 2^WIDTH:
  - 000 ADD: a+b.
  - 001 SUB: a-b.
  - 010 AND.
  - 011 OR.
  - 100 XOR.
  - 101 SHL: a<<b.
  - 110 SHR: logical a>>b. For both shifts, b>=WIDTH gives 0.
  - 111 ACC: out+b, where out is the previously registered result (running accumulator).
- Flag rules:
  - N: out[WIDTH-1].
  - Z: out==0.
  - C: carry-out for ADD/ACC; borrow (a<b, unsigned) for SUB; 0 for all other ops.
  - V: two's-complement overflow for ADD/SUB/ACC; 0 for all other ops.
- Segment encoding: standard hex 0-F; digit 0 = 7'b1000000.

## Timing
- Reset values, applied at the first rising edge with rst_n=0:
  - out=0, flags=4'b0100 (Z set), busy=0, done=0.
  - seg_lo=seg_hi=7'b1000000.
  - FSM=IDLE, debounced level=1 (released), debounce counter=0, synchroniser flops=1.
- Raw-press-to-done latency: exactly DEBOUNCE_CYCLES+5 rising edges, counted from the first edge that samples btn_n=0. Breakdown: 2 synchroniser, DEBOUNCE_CYCLES debounce, press_pulse->CAPTURE, EXEC, DONE.
- Output timing:
  - out, flags and segments change on the edge that enters DONE, together with done=1.
  - All of them hold until the next EXEC.
- Operand timing: a, b and op are sampled only in CAPTURE. Switch changes at any other time have no effect.
- Reset mid-operation (any non-IDLE state): on the next edge the FSM returns to IDLE, all outputs take their reset values and no done is issued.
- A press completing in the same cycle that rst_n deasserts is lost.

## Configuration
- SEQ_CALC_FLAGS_EN defined: flags computed as above.
- SEQ_CALC_FLAGS_EN undefined:
  - flags tied to 4'b0000; no flag logic is synthesised.
  - out, done, busy and segments are unchanged.

## Test plan
- Reset: hold rst_n=0 for 3 edges with WIDTH=4 -> out=0, flags=0100, seg_lo=seg_hi=1000000, busy=0.
- ADD with carry: a=1001, b=1000, op=000, one clean press -> done exactly DEBOUNCE_CYCLES+5 edges later; out=0001, flags N0 Z0 C1 V1, seg_lo=1111001.
- Bounce rejection: btn_n low for DEBOUNCE_CYCLES-1 cycles, then high -> no done and busy stays 0. A following clean press of SUB a=0011, b=0101 -> out=1110, flags N1 Z0 C1 V0.
- ACC and busy discard:
  - From out=0, three clean presses of op=111 with b=0110 -> out sequence 0110, 1100, 0010 (last C=1).
  - A second press inside busy -> exactly one done.
- Shifts: op=101, a=0011, b=0010 -> 1100. op=110, a=1000, b=0100 -> 0000, flags Z=1.
- Mid-operation reset: rst_n=0 on the EXEC cycle -> no done; out=0 and busy=0 after that edge. Repeat with the macro undefined -> flags stay 0000 throughout.

Source files
------------

// File: rtl/seq_param_calculator.sv
// seq_param_calculator: clocked switch calculator. A debounced press of the
// active-low KEY0 button captures a, b and op, computes one operation and
// holds the registered result, flags and two active-low hex digits until the
// next press.
// Optional feature macro: SEQ_CALC_FLAGS_EN (defined = N/Z/C/V flags are
// computed; undefined = flags tied to 4'b0000 and no flag logic is built).
module seq_param_calculator #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             btn_n,
  output logic [WIDTH-1:0] out,
  output logic [3:0]       flags,
  output logic             busy,
  output logic             done,
  output logic [6:0]       seg_lo,
  output logic [6:0]       seg_hi
);

  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [WIDTH-1:0] SHIFT_LIMIT = WIDTH'(WIDTH);

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_SHL = 3'b101;
  localparam logic [2:0] OP_SHR = 3'b110;
  localparam logic [2:0] OP_ACC = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_CAPTURE = 2'd1,
    S_EXEC    = 2'd2,
    S_DONE    = 2'd3
  } state_t;

  state_t           state;
  state_t           state_next;
  logic             sync1;
  logic             sync2;
  logic             deb_level;
  logic [CNT_W-1:0] deb_cnt;
  logic             press_pulse;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] lhs;
  logic [WIDTH-1:0] res;
  logic [7:0]       out_ext;

  // Two-flop synchroniser for the asynchronous button; idles released (1).
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b1;
      sync2 <= 1'b1;
    end else begin
      sync1 <= btn_n;
      sync2 <= sync1;
    end
  end

  // Debouncer: accept a new level after DEBOUNCE_CYCLES consecutive
  // differing samples, and pulse once when the accepted level falls.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deb_level   <= 1'b1;
      deb_cnt     <= '0;
      press_pulse <= 1'b0;
    end else if (sync2 != deb_level) begin
      if (deb_cnt == CNT_MAX) begin
        deb_level   <= sync2;
        deb_cnt     <= '0;
        press_pulse <= ~sync2;
      end else begin
        deb_cnt     <= deb_cnt + 1'b1;
        press_pulse <= 1'b0;
      end
    end else begin
      deb_cnt     <= '0;
      press_pulse <= 1'b0;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_next;
  end

  // Next-state logic; presses outside IDLE are simply dropped.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:    if (press_pulse) state_next = S_CAPTURE;
      S_CAPTURE: state_next = S_EXEC;
      S_EXEC:    state_next = S_DONE;
      S_DONE:    state_next = S_IDLE;
      default:   state_next = S_IDLE;
    endcase
  end

  assign busy = (state != S_IDLE);
  assign done = (state == S_DONE);

  // Operand capture: switches are only looked at in CAPTURE.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q  <= '0;
      b_q  <= '0;
      op_q <= 3'b000;
    end else if (state == S_CAPTURE) begin
      a_q  <= a;
      b_q  <= b;
      op_q <= op;
    end
  end

  // ALU: ACC reuses the adder with the held result as its left operand.
  always_comb begin
    lhs = (op_q == OP_ACC) ? out : a_q;
    res = '0;
    case (op_q)
      OP_ADD, OP_ACC: res = lhs + b_q;
      OP_SUB:         res = a_q - b_q;
      OP_AND:         res = a_q & b_q;
      OP_OR:          res = a_q | b_q;
      OP_XOR:         res = a_q ^ b_q;
      OP_SHL:         res = (b_q >= SHIFT_LIMIT) ? '0 : (a_q << b_q);
      OP_SHR:         res = (b_q >= SHIFT_LIMIT) ? '0 : (a_q >> b_q);
      default:        res = '0;
    endcase
  end

  // Result register, loaded on the edge that leaves EXEC for DONE.
  always_ff @(posedge clk) begin
    if (!rst_n)                 out <= '0;
    else if (state == S_EXEC)   out <= res;
  end

`ifdef SEQ_CALC_FLAGS_EN
  logic [WIDTH:0] add_ext;
  logic           c_flag;
  logic           v_flag;

  // Carry and overflow for the arithmetic ops; logic ops leave them clear.
  always_comb begin
    add_ext = {1'b0, lhs} + {1'b0, b_q};
    c_flag  = 1'b0;
    v_flag  = 1'b0;
    case (op_q)
      OP_ADD, OP_ACC: begin
        c_flag = add_ext[WIDTH];
        v_flag = (lhs[WIDTH-1] == b_q[WIDTH-1]) && (res[WIDTH-1] != lhs[WIDTH-1]);
      end
      OP_SUB: begin
        c_flag = (a_q < b_q);
        v_flag = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res[WIDTH-1] != a_q[WIDTH-1]);
      end
      default: begin
        c_flag = 1'b0;
        v_flag = 1'b0;
      end
    endcase
  end

  // Flag register {N,Z,C,V}, updated together with the result.
  always_ff @(posedge clk) begin
    if (!rst_n)               flags <= 4'b0100;
    else if (state == S_EXEC) flags <= {res[WIDTH-1], (res == '0), c_flag, v_flag};
  end
`else
  assign flags = 4'b0000;
`endif

  function automatic logic [6:0] hex7(input logic [3:0] v);
    case (v)
      4'h0: hex7 = 7'b1000000;
      4'h1: hex7 = 7'b1111001;
      4'h2: hex7 = 7'b0100100;
      4'h3: hex7 = 7'b0110000;
      4'h4: hex7 = 7'b0011001;
      4'h5: hex7 = 7'b0010010;
      4'h6: hex7 = 7'b0000010;
      4'h7: hex7 = 7'b1111000;
      4'h8: hex7 = 7'b0000000;
      4'h9: hex7 = 7'b0010000;
      4'hA: hex7 = 7'b0001000;
      4'hB: hex7 = 7'b0000011;
      4'hC: hex7 = 7'b1000110;
      4'hD: hex7 = 7'b0100001;
      4'hE: hex7 = 7'b0000110;
      default: hex7 = 7'b0001110;
    endcase
  endfunction

  // Displays follow the held result; bits above WIDTH read as zero.
  assign out_ext = 8'(out);
  assign seg_lo  = hex7(out_ext[3:0]);
  assign seg_hi  = hex7(out_ext[7:4]);

endmodule

// File: tb/tb_seq_param_calculator.sv
// tb_seq_param_calculator: directed vectors for seq_param_calculator.
// A DEBOUNCE_CYCLES=1 instance is added so a second press can land while busy.
module tb_seq_param_calculator;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         rst_n, btn_n;
  logic [W-1:0] a, b, out;
  logic [2:0]   op;
  logic [3:0]   flags;
  logic         busy, done;
  logic [6:0]   seg_lo, seg_hi;

  logic         f_rst_n, f_btn_n;
  logic [W-1:0] f_a, f_b, f_out;
  logic [2:0]   f_op;
  logic [3:0]   f_flags;
  logic         f_busy, f_done;
  logic [6:0]   f_seg_lo, f_seg_hi;

  int checks = 0;
  int passed = 0;

  always #5 clk = ~clk;

  seq_param_calculator #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .op(op), .btn_n(btn_n),
    .out(out), .flags(flags), .busy(busy), .done(done),
    .seg_lo(seg_lo), .seg_hi(seg_hi)
  );

  seq_param_calculator #(.WIDTH(W), .DEBOUNCE_CYCLES(1)) dut_fast (
    .clk(clk), .rst_n(f_rst_n), .a(f_a), .b(f_b), .op(f_op), .btn_n(f_btn_n),
    .out(f_out), .flags(f_flags), .busy(f_busy), .done(f_done),
    .seg_lo(f_seg_lo), .seg_hi(f_seg_hi)
  );

  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
    logic [3:0] exp_out;
    logic [3:0] exp_flags;
    logic [6:0] exp_seg;
  } vec_t;

  vec_t vecs[14];

  function automatic logic [3:0] exp_f(input logic [3:0] f);
`ifdef SEQ_CALC_FLAGS_EN
    return f;
`else
    return 4'b0000 & f;
`endif
  endfunction

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("[TB] FAIL %s: got %0b, expected %0b", name, act, exp);
  endtask

  // One clean press: btn_n low is sampled on edge 1; returns the edge index of done.
  task automatic apply_stimulus(input logic [3:0] va, input logic [3:0] vb,
                                input logic [2:0] vop, output int lat);
    a = va; b = vb; op = vop; btn_n = 1'b0; lat = -1;
    for (int i = 1; i <= D + 12 && lat < 0; i++) begin
      @(posedge clk); #1;
      if (done) lat = i;
    end
    btn_n = 1'b1;
    repeat (D + 6) @(posedge clk);
    #1;
  endtask

  initial begin
    int lat;
    logic saw_done, saw_busy;
    int dones;

    vecs[0]  = '{4'b1001, 4'b1000, 3'b000, 4'b0001, 4'b0011, 7'b1111001};
    vecs[1]  = '{4'b0011, 4'b0101, 3'b001, 4'b1110, 4'b1010, 7'b0000110};
    vecs[2]  = '{4'b1100, 4'b1010, 3'b010, 4'b1000, 4'b1000, 7'b0000000};
    vecs[3]  = '{4'b0101, 4'b0010, 3'b011, 4'b0111, 4'b0000, 7'b1111000};
    vecs[4]  = '{4'b1111, 4'b1111, 3'b100, 4'b0000, 4'b0100, 7'b1000000};
    vecs[5]  = '{4'b0011, 4'b0010, 3'b101, 4'b1100, 4'b1000, 7'b1000110};
    vecs[6]  = '{4'b1000, 4'b0100, 3'b110, 4'b0000, 4'b0100, 7'b1000000};
    vecs[7]  = '{4'b0001, 4'b0101, 3'b101, 4'b0000, 4'b0100, 7'b1000000};
    vecs[8]  = '{4'b1111, 4'b0110, 3'b111, 4'b0110, 4'b0000, 7'b0000010};
    vecs[9]  = '{4'b1111, 4'b0110, 3'b111, 4'b1100, 4'b1001, 7'b1000110};
    vecs[10] = '{4'b1111, 4'b0110, 3'b111, 4'b0010, 4'b0010, 7'b0100100};
    vecs[11] = '{4'b1101, 4'b0001, 3'b110, 4'b0110, 4'b0000, 7'b0000010};
    vecs[12] = '{4'b0101, 4'b0101, 3'b001, 4'b0000, 4'b0100, 7'b1000000};
    vecs[13] = '{4'b1000, 4'b0001, 3'b001, 4'b0111, 4'b0001, 7'b1111000};

    rst_n = 1'b0; btn_n = 1'b1; a = '0; b = '0; op = 3'b000;
    f_rst_n = 1'b0; f_btn_n = 1'b1; f_a = '0; f_b = '0; f_op = 3'b000;
    repeat (3) @(posedge clk);
    #1;
    check_output("reset out", 32'(out), 32'(4'b0000));
    check_output("reset flags", 32'(flags), 32'(exp_f(4'b0100)));
    check_output("reset seg_lo", 32'(seg_lo), 32'(7'b1000000));
    check_output("reset seg_hi", 32'(seg_hi), 32'(7'b1000000));
    check_output("reset busy", 32'(busy), 32'(1'b0));
    check_output("reset done", 32'(done), 32'(1'b0));
    rst_n = 1'b1; f_rst_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;

    // Bounce shorter than the debounce window must be ignored.
    saw_done = 1'b0; saw_busy = 1'b0;
    for (int i = 0; i < 25; i++) begin
      btn_n = (i < D - 1) ? 1'b0 : 1'b1;
      @(posedge clk); #1;
      saw_done |= done;
      saw_busy |= busy;
    end
    check_output("bounce done", 32'(saw_done), 32'(1'b0));
    check_output("bounce busy", 32'(saw_busy), 32'(1'b0));

    for (int k = 0; k < 14; k++) begin
      apply_stimulus(vecs[k].a, vecs[k].b, vecs[k].op, lat);
      $display("[TB] vector %0d op=%b a=%b b=%b out=%b flags=%b", k, vecs[k].op,
               vecs[k].a, vecs[k].b, out, flags);
      check_output($sformatf("v%0d latency", k), 32'(lat), 32'(D + 5));
      check_output($sformatf("v%0d out", k), 32'(out), 32'(vecs[k].exp_out));
      check_output($sformatf("v%0d flags", k), 32'(flags), 32'(exp_f(vecs[k].exp_flags)));
      check_output($sformatf("v%0d seg_lo", k), 32'(seg_lo), 32'(vecs[k].exp_seg));
      check_output($sformatf("v%0d seg_hi", k), 32'(seg_hi), 32'(7'b1000000));
    end

    // Reset while in EXEC: no done, outputs return to reset values.
    a = 4'b0001; b = 4'b0001; op = 3'b000; btn_n = 1'b0;
    repeat (D + 4) @(posedge clk);
    #1;
    check_output("midrst busy before", 32'(busy), 32'(1'b1));
    rst_n = 1'b0; btn_n = 1'b1;
    @(posedge clk); #1;
    check_output("midrst done", 32'(done), 32'(1'b0));
    check_output("midrst out", 32'(out), 32'(4'b0000));
    check_output("midrst busy", 32'(busy), 32'(1'b0));
    check_output("midrst flags", 32'(flags), 32'(exp_f(4'b0100)));
    check_output("midrst seg_lo", 32'(seg_lo), 32'(7'b1000000));
    rst_n = 1'b1;
    saw_done = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      saw_done |= done;
    end
    check_output("midrst later done", 32'(saw_done), 32'(1'b0));
    check_output("midrst later out", 32'(out), 32'(4'b0000));

    // Second press arriving while busy on the fast instance is discarded.
    f_a = 4'b1111; f_b = 4'b0011; f_op = 3'b111; dones = 0;
    f_btn_n = 1'b0; @(posedge clk); #1;
    f_btn_n = 1'b1; @(posedge clk); #1;
    f_btn_n = 1'b0;
    for (int i = 0; i < 25; i++) begin
      @(posedge clk); #1;
      if (f_done) dones++;
    end
    f_btn_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check_output("discard done count", 32'(dones), 32'd1);
    check_output("discard out", 32'(f_out), 32'(4'b0011));
    check_output("discard flags", 32'(f_flags), 32'(exp_f(4'b0000)));
    check_output("discard seg_lo", 32'(f_seg_lo), 32'(7'b0110000));

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
